// File: rtl/scntl_to_simd_regfile_tx.sv
// Moves streamingOps stOp result words into consecutive SIMD regfile registers
// through a small FIFO. Defining SCNTL_TX_WORD_COUNT_EN adds the rf_word_count output.
module scntl_to_simd_regfile_tx #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset_poweron,
   input  logic                  cfg_start,
   input  logic [REG_ADDR_W-1:0] cfg_base_addr,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [DATA_W-1:0]     res_data,
   input  logic                  res_last,
   output logic                  rf_wr_valid,
   input  logic                  rf_wr_ready,
   output logic [REG_ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0]     rf_wr_data,
   output logic                  rf_complete,
   output logic                  busy
`ifdef SCNTL_TX_WORD_COUNT_EN
   ,
   output logic [REG_ADDR_W:0]   rf_word_count
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]            state;
   logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
   logic                  fifo_last [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W:0]        count;
   logic                  last_seen;
   logic [REG_ADDR_W-1:0] addr_ptr;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  head_last;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   assign fifo_full   = (count == DEPTH_C);
   assign fifo_empty  = (count == '0);
   assign res_ready   = (state == ST_XFER) && !fifo_full && !last_seen;
   assign push        = res_valid && res_ready;
   assign rf_wr_valid = !fifo_empty;
   assign pop         = rf_wr_valid && rf_wr_ready;
   assign head_last   = fifo_last[rd_ptr];
   // Stale FIFO storage is never exposed: the data bus reads zero while empty.
   assign rf_wr_data  = fifo_empty ? '0 : fifo_data[rd_ptr];
   assign rf_wr_addr  = addr_ptr;
   assign rf_complete = (state == ST_DONE);
   assign busy        = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= res_data;
         fifo_last[wr_ptr] <= res_last;
      end
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Once the last-flagged word is in, intake stays closed until the next start.
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         state     <= ST_IDLE;
         last_seen <= 1'b0;
         addr_ptr  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_start) begin
                  addr_ptr  <= cfg_base_addr;
                  last_seen <= 1'b0;
                  state     <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (push && res_last) last_seen <= 1'b1;
               if (pop && head_last) state <= ST_DONE;
               if (pop) addr_ptr <= addr_ptr + 1'b1;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SCNTL_TX_WORD_COUNT_EN
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         rf_word_count <= '0;
      end else if (state == ST_IDLE && cfg_start) begin
         rf_word_count <= '0;
      end else if (pop && rf_word_count != '1) begin
         rf_word_count <= rf_word_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_scntl_to_simd_regfile_tx.sv
// Directed bench for scntl_to_simd_regfile_tx; regfile writes are checked against
// a queue of expected {addr,data}. Define SCNTL_TX_WORD_COUNT_EN to cover rf_word_count.
module tb_scntl_to_simd_regfile_tx;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int REG_ADDR_W = 5;

   logic                  clk = 1'b0;
   logic                  reset_poweron = 1'b1;
   logic                  cfg_start = 1'b0;
   logic [REG_ADDR_W-1:0] cfg_base_addr = '0;
   logic                  res_valid = 1'b0;
   logic                  res_ready;
   logic [DATA_W-1:0]     res_data = '0;
   logic                  res_last = 1'b0;
   logic                  rf_wr_valid;
   logic                  rf_wr_ready = 1'b1;
   logic [REG_ADDR_W-1:0] rf_wr_addr;
   logic [DATA_W-1:0]     rf_wr_data;
   logic                  rf_complete;
   logic                  busy;
`ifdef SCNTL_TX_WORD_COUNT_EN
   logic [REG_ADDR_W:0]   rf_word_count;
`endif

   int checks = 0;
   int errors = 0;
   int res_acc = 0;
   int cmpl_cnt = 0;
   int cmpl_exp = 0;
   logic [REG_ADDR_W+DATA_W-1:0] sb [$];
   logic [REG_ADDR_W+DATA_W-1:0] sb_entry;
   logic                  hold_pending = 1'b0;
   logic [REG_ADDR_W-1:0] hold_addr = '0;
   logic [DATA_W-1:0]     hold_data = '0;

   scntl_to_simd_regfile_tx #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .REG_ADDR_W(REG_ADDR_W)
   ) dut (
      .clk(clk), .reset_poweron(reset_poweron),
      .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
      .rf_wr_valid(rf_wr_valid), .rf_wr_ready(rf_wr_ready),
      .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .rf_complete(rf_complete), .busy(busy)
`ifdef SCNTL_TX_WORD_COUNT_EN
      , .rf_word_count(rf_word_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshakes are sampled on the falling edge, between input updates and the next rising edge.
   always @(negedge clk) begin
      if (reset_poweron) begin
         if (hold_pending) begin
            check("hold_valid", rf_wr_valid, 1);
            check("hold_addr", rf_wr_addr, hold_addr);
            check("hold_data", rf_wr_data, hold_data);
         end
         if (res_valid && res_ready) res_acc++;
         if (rf_complete) cmpl_cnt++;
         if (rf_wr_valid && rf_wr_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL sb_underflow observed write addr %0h data %0h expected none", rf_wr_addr, rf_wr_data);
            end else begin
               sb_entry = sb.pop_front();
               check("wr_addr", rf_wr_addr, sb_entry[REG_ADDR_W+DATA_W-1:DATA_W]);
               check("wr_data", rf_wr_data, sb_entry[DATA_W-1:0]);
            end
         end
         hold_pending = rf_wr_valid && !rf_wr_ready;
         hold_addr    = rf_wr_addr;
         hold_data    = rf_wr_data;
      end else begin
         hold_pending = 1'b0;
      end
   end

   task automatic start_op(input logic [REG_ADDR_W-1:0] base);
      cfg_base_addr = base;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("start_busy", busy, 1);
      check("start_addr", rf_wr_addr, base);
`ifdef SCNTL_TX_WORD_COUNT_EN
      check("count_cleared", rf_word_count, 0);
`endif
   endtask

   task automatic send_word(input logic [DATA_W-1:0] d, input logic l, input logic [REG_ADDR_W-1:0] a);
      bit ok;
      ok = 1'b0;
      sb.push_back({a, d});
      res_data = d;
      res_last = l;
      res_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (res_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) tick();
      check("send_accepted", ok, 1);
      res_valid = 1'b0;
      res_last = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rf_complete) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check("done_seen", seen, 1);
      cmpl_exp++;
      tick();
      check("done_idle", busy, 0);
      check("done_pulse_count", cmpl_cnt, cmpl_exp);
      check("sb_drained", sb.size(), 0);
   endtask

   // Four words with the regfile always ready: one-cycle latency and a single done pulse.
   task automatic run_basic(input logic [REG_ADDR_W-1:0] base);
      logic [REG_ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      start_op(base);
      check("basic_empty", rf_wr_valid, 0);
      for (int i = 0; i < 4; i++) begin
         a = base + REG_ADDR_W'(i);
         d = 32'hA000_0000 | DATA_W'(i);
         send_word(d, (i == 3), a);
         check("basic_valid", rf_wr_valid, 1);
         check("basic_data", rf_wr_data, d);
         check("basic_addr", rf_wr_addr, a);
         check("basic_no_done", rf_complete, 0);
      end
      tick();
      cmpl_exp++;
      check("basic_done", rf_complete, 1);
      check("basic_done_empty", rf_wr_valid, 0);
      tick();
      check("basic_done_once", rf_complete, 0);
      check("basic_idle", busy, 0);
      check("basic_pulse_count", cmpl_cnt, cmpl_exp);
      check("basic_sb_drained", sb.size(), 0);
`ifdef SCNTL_TX_WORD_COUNT_EN
      check("count_after_done", rf_word_count, 4);
      tick();
      check("count_held", rf_word_count, 4);
`endif
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_res_ready"}, res_ready, 0);
      check({tag, "_wr_valid"}, rf_wr_valid, 0);
      check({tag, "_complete"}, rf_complete, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_addr"}, rf_wr_addr, 0);
      check({tag, "_data"}, rf_wr_data, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2 reset_poweron = 1'b0;
      #1 check_zero_outputs("reset");
      tick();
      tick();
      reset_poweron = 1'b1;
      tick();
      check_zero_outputs("post_reset");

      $display("[TB] basic transfer, base 3");
      run_basic(5'd3);

      $display("[TB] address wrap, base 30");
      run_basic(5'd30);

      $display("[TB] backpressure with six words");
      rf_wr_ready = 1'b0;
      res_acc = 0;
      start_op(5'd10);
      for (int i = 0; i < 4; i++) send_word(32'hB000_0000 | DATA_W'(i), 1'b0, 5'd10 + 5'(i));
      res_data = 32'hB000_0004;
      res_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_res_ready", res_ready, 0);
         check("bp_valid", rf_wr_valid, 1);
         check("bp_addr", rf_wr_addr, 10);
         check("bp_data", rf_wr_data, 32'hB000_0000);
      end
      check("bp_accepted", res_acc, 4);
      rf_wr_ready = 1'b1;
      send_word(32'hB000_0004, 1'b0, 5'd14);
      send_word(32'hB000_0005, 1'b1, 5'd15);
      wait_done();
      check("bp_total_accepted", res_acc, 6);

      $display("[TB] idle valid and start during transfer");
      res_acc = 0;
      res_data = 32'hC000_0000;
      res_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_res_ready", res_ready, 0);
      end
      res_valid = 1'b0;
      check("idle_no_accept", res_acc, 0);
      start_op(5'd7);
      send_word(32'hC000_0000, 1'b0, 5'd7);
      cfg_base_addr = 5'd20;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("restart_addr", rf_wr_addr, 8);
      check("restart_busy", busy, 1);
      send_word(32'hC000_0001, 1'b1, 5'd8);
      wait_done();

      $display("[TB] reset mid-transfer");
      rf_wr_ready = 1'b0;
      start_op(5'd0);
      send_word(32'hD000_0000, 1'b0, 5'd0);
      send_word(32'hD000_0001, 1'b0, 5'd1);
      res_data = 32'hD000_0002;
      res_valid = 1'b1;
      check("pre_reset_valid", rf_wr_valid, 1);
      #2 reset_poweron = 1'b0;
      #1 check_zero_outputs("async_reset");
      sb.delete();
      res_valid = 1'b0;
      tick();
      tick();
      check_zero_outputs("held_reset");
      check("reset_no_done", cmpl_cnt, cmpl_exp);
      reset_poweron = 1'b1;
      rf_wr_ready = 1'b1;
      tick();
      check("after_reset_empty", rf_wr_valid, 0);
      check("after_reset_idle", busy, 0);
      run_basic(5'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
